// File: rtl/ez8_fetch_pkg.sv
// ez8 fetch sequencer shared definitions.
// FSM state encoding and default geometry of the instruction store.
package ez8_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam int EZ8_PC_W      = 7;
    localparam int EZ8_INSTR_W   = 12;
    localparam int EZ8_BOOT_ADDR = 0;
    localparam int EZ8_STK_DEPTH = 4;

    // Next sequential word address, wrapping at the top of memory.
    function automatic logic [EZ8_PC_W-1:0] pc_next(
        input logic [EZ8_PC_W-1:0] pc
    );
        return pc + EZ8_PC_W'(1);
    endfunction

endpackage

// File: rtl/ez8_return_stack.sv
// ez8 return-address LIFO with push/pop, full/empty flags and sp counter.
// The caller never pushes when full nor pops when empty.
import ez8_fetch_pkg::*;

module ez8_return_stack #(
    parameter int DEPTH = EZ8_STK_DEPTH,
    parameter int W     = EZ8_PC_W
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_top,
    output logic         o_full,
    output logic         o_empty
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]   r_mem [DEPTH];
    logic [SPW-1:0] r_sp;
    logic [IW-1:0]  w_wr_idx;
    logic [IW-1:0]  w_rd_idx;

    assign w_wr_idx = r_sp[IW-1:0];
    assign w_rd_idx = IW'(r_sp - SPW'(1));
    assign o_full   = (r_sp == SPW'(DEPTH));
    assign o_empty  = (r_sp == '0);
    assign o_top    = r_mem[w_rd_idx];

    // Stack pointer: counts live entries.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sp <= '0;
        end else if (i_push && !o_full) begin
            r_sp <= r_sp + SPW'(1);
        end else if (i_pop && !o_empty) begin
            r_sp <= r_sp - SPW'(1);
        end
    end

    // Entry storage; contents need no reset since sp gates reads.
    always_ff @(posedge i_clk) begin
        if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_din;
        end
    end

endmodule

// File: rtl/ez8_fetch_sequencer.sv
// ez8 PC sequencer and 1-deep fetch buffer feeding decode.
// Optional call/return stack enabled by EZ8_FETCH_RETSTACK_EN.
import ez8_fetch_pkg::*;

module ez8_fetch_sequencer #(
    parameter int PC_W      = EZ8_PC_W,
    parameter int INSTR_W   = EZ8_INSTR_W,
    parameter int BOOT_ADDR = EZ8_BOOT_ADDR,
    parameter int STK_DEPTH = EZ8_STK_DEPTH
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_run,
    input  logic               i_halt_req,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic [INSTR_W-1:0] o_instr_out,
    output logic [PC_W-1:0]    o_instr_pc,
    output logic               o_instr_valid,
    input  logic               i_instr_ready,
    input  logic               i_redirect_valid,
    input  logic [PC_W-1:0]    i_redirect_target,
    input  logic               i_call_valid,
    input  logic               i_ret_valid,
    output logic               o_halted,
    output logic               o_stack_err
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_HALT = HALT;

    logic [1:0]         r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_instr_pc;
    logic               r_valid;

    logic            w_accept;
    logic            w_advance;
    logic            w_redir;
    logic            w_call;
    logic            w_ret;
    logic            w_pop_ok;
    logic            w_underflow;
    logic            w_taken;
    logic            w_stop;
    logic            w_fetch;
    logic [PC_W-1:0] w_top;
    logic [PC_W-1:0] w_new_pc;

    assign w_accept  = r_valid & i_instr_ready;
    assign w_advance = (r_state == ST_RUN)
                     & (~r_valid | i_instr_ready);
    assign w_redir   = w_accept & i_redirect_valid;

`ifdef EZ8_FETCH_RETSTACK_EN
    logic w_full;
    logic w_empty;
    logic w_push;
    logic r_stack_err;

    assign w_ret = w_accept & ~i_redirect_valid
                 & i_ret_valid;
    assign w_call = w_accept & ~i_redirect_valid
                  & ~i_ret_valid & i_call_valid;
    assign w_pop_ok    = w_ret & ~w_empty;
    assign w_underflow = w_ret & w_empty;
    assign w_push      = w_call & ~w_full;

    ez8_return_stack #(
        .DEPTH (STK_DEPTH),
        .W     (PC_W)
    ) u_rstack (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop_ok),
        .i_din   (r_instr_pc + PC_W'(1)),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Sticky flag for any overflow or underflow.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stack_err <= 1'b0;
        end else if ((w_call & w_full) | w_underflow) begin
            r_stack_err <= 1'b1;
        end
    end

    assign o_stack_err = r_stack_err;
`else
    logic w_unused;

    assign w_unused    = i_call_valid ^ i_ret_valid;
    assign w_ret       = 1'b0;
    assign w_call      = 1'b0;
    assign w_pop_ok    = 1'b0;
    assign w_underflow = 1'b0;
    assign w_top       = '0;
    assign o_stack_err = 1'b0;
`endif

    assign w_taken  = w_redir | w_call | w_pop_ok;
    assign w_new_pc = w_pop_ok ? w_top : i_redirect_target;
    assign w_stop   = i_halt_req | w_underflow;
    assign w_fetch  = w_advance & ~w_stop;

    // Control FSM: halt wins over run while running.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (i_run) r_state <= ST_RUN;
                ST_RUN:  if (w_stop) r_state <= ST_HALT;
                ST_HALT: if (i_run) r_state <= ST_RUN;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // PC and fetch buffer: redirect, then fetch, then drain.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc       <= PC_W'(BOOT_ADDR);
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
        end else if (w_taken) begin
            r_pc    <= w_new_pc;
            r_valid <= 1'b0;
        end else if (w_fetch) begin
            r_instr    <= i_imem_rdata;
            r_instr_pc <= r_pc;
            r_valid    <= 1'b1;
            r_pc       <= r_pc + PC_W'(1);
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    assign o_imem_addr   = r_pc;
    assign o_instr_out   = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_valid;
    assign o_halted      = (r_state == ST_HALT) & ~r_valid;

endmodule

// File: tb/tb_ez8_fetch_sequencer.sv
// Directed bench for ez8_fetch_sequencer.
// Stack scenarios run only when EZ8_FETCH_RETSTACK_EN is defined.
module tb_ez8_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        halt_req;
    logic [6:0]  imem_addr;
    logic [11:0] imem_rdata;
    logic [11:0] instr_out;
    logic [6:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [6:0]  redirect_target;
    logic        call_valid;
    logic        ret_valid;
    logic        halted;
    logic        stack_err;

    logic [11:0] mem [128];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    ez8_fetch_sequencer dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_run             (run),
        .i_halt_req        (halt_req),
        .o_imem_addr       (imem_addr),
        .i_imem_rdata      (imem_rdata),
        .o_instr_out       (instr_out),
        .o_instr_pc        (instr_pc),
        .o_instr_valid     (instr_valid),
        .i_instr_ready     (instr_ready),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .i_call_valid      (call_valid),
        .i_ret_valid       (ret_valid),
        .o_halted          (halted),
        .o_stack_err       (stack_err)
    );

    function automatic logic [11:0] word_at(input int a);
        return 12'h101 + 12'(a);
    endfunction

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input string tag, input int a);
        check({tag, "_v"}, 32'(instr_valid), 32'd1);
        check({tag, "_pc"}, 32'(instr_pc), 32'(a));
        check({tag, "_out"}, 32'(instr_out), 32'(word_at(a)));
    endtask

    task automatic redirect_to(input int tgt);
        redirect_valid  = 1'b1;
        redirect_target = 7'(tgt);
        step();
        check("redir_bubble", 32'(instr_valid), 32'd0);
        check("redir_addr", 32'(imem_addr), 32'(tgt));
        redirect_valid = 1'b0;
        step();
        expect_word("redir_dst", tgt);
    endtask

    task automatic call_to(input int tgt);
        call_valid      = 1'b1;
        redirect_target = 7'(tgt);
        step();
        check("call_bubble", 32'(instr_valid), 32'd0);
        call_valid = 1'b0;
        step();
        expect_word("call_dst", tgt);
    endtask

    task automatic ret_to(input int a);
        ret_valid = 1'b1;
        step();
        check("ret_bubble", 32'(instr_valid), 32'd0);
        ret_valid = 1'b0;
        step();
        expect_word("ret_dst", a);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = word_at(i);
        reset           = 1'b1;
        run             = 1'b0;
        halt_req        = 1'b0;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        call_valid      = 1'b0;
        ret_valid       = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_out", 32'(instr_out), 32'd0);
        check("rst_ipc", 32'(instr_pc), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_serr", 32'(stack_err), 32'd0);

        // Start: first word one cycle after RUN.
        run         = 1'b1;
        instr_ready = 1'b1;
        step();
        run = 1'b0;
        check("run_first_v", 32'(instr_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            expect_word("seq", k);
        end

        // Stall at instr_pc 5.
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_word("stall", 5);
            check("stall_addr", 32'(imem_addr), 32'd6);
        end
        instr_ready = 1'b1;
        step();
        expect_word("release", 6);
        step();
        step();
        expect_word("seq8", 8);

        redirect_to(7'h40);
        step();
        expect_word("after_redir", 7'h41);

`ifdef EZ8_FETCH_RETSTACK_EN
        redirect_to(7'h10);
        call_to(7'h60);
        step();
        expect_word("sub", 7'h61);
        step();
        expect_word("sub", 7'h62);
        ret_to(7'h11);
        check("serr_ok", 32'(stack_err), 32'd0);

        call_to(7'h20);
        call_to(7'h28);
        call_to(7'h30);
        call_to(7'h38);
        check("serr_4", 32'(stack_err), 32'd0);
        call_to(7'h50);
        check("serr_5", 32'(stack_err), 32'd1);
        ret_to(7'h31);
        ret_to(7'h29);
        ret_to(7'h21);
        ret_to(7'h12);

        ret_valid = 1'b1;
        step();
        ret_valid = 1'b0;
        check("uflow_v", 32'(instr_valid), 32'd0);
        check("uflow_halt", 32'(halted), 32'd1);
        check("uflow_addr", 32'(imem_addr), 32'h13);
        run = 1'b1;
        step();
        run = 1'b0;
        step();
        expect_word("resume", 7'h13);
`else
        call_valid      = 1'b1;
        redirect_target = 7'h60;
        step();
        call_valid = 1'b0;
        expect_word("call_ign", 7'h42);
        ret_valid = 1'b1;
        step();
        ret_valid = 1'b0;
        expect_word("ret_ign", 7'h43);
        check("serr_tied", 32'(stack_err), 32'd0);
`endif

        // PC wrap.
        redirect_to(7'h7E);
        step();
        expect_word("top", 7'h7F);
        step();
        expect_word("wrap", 0);

        // Halt with a pending word.
        instr_ready = 1'b0;
        halt_req    = 1'b1;
        step();
        halt_req = 1'b0;
        check("hreq_held", 32'(instr_valid), 32'd1);
        check("hreq_nothalt", 32'(halted), 32'd0);
        step();
        check("hreq_wait", 32'(halted), 32'd0);
        instr_ready = 1'b1;
        step();
        check("halted", 32'(halted), 32'd1);
        step();
        check("halt_nofetch", 32'(instr_valid), 32'd0);
        check("halt_addr", 32'(imem_addr), 32'd1);
        run = 1'b1;
        step();
        run = 1'b0;
        step();
        expect_word("resume2", 1);

        // run and halt_req together: halt wins.
        run         = 1'b1;
        halt_req    = 1'b1;
        instr_ready = 1'b0;
        step();
        run      = 1'b0;
        halt_req = 1'b0;
        expect_word("both_hold", 1);
        instr_ready = 1'b1;
        step();
        check("both_halted", 32'(halted), 32'd1);
        run = 1'b1;
        step();
        run = 1'b0;
        step();
        expect_word("resume3", 2);

        // Reset mid-RUN.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_v", 32'(instr_valid), 32'd0);
        check("mrst_addr", 32'(imem_addr), 32'd0);
        check("mrst_ipc", 32'(instr_pc), 32'd0);
        check("mrst_halted", 32'(halted), 32'd0);
        check("mrst_serr", 32'(stack_err), 32'd0);
        step();
        check("mrst_idle", 32'(instr_valid), 32'd0);
        check("mrst_idle_addr", 32'(imem_addr), 32'd0);

        $display("Result: errors=%0d of %0d checks",
                 n_errors, n_checks);
        $finish;
    end

endmodule
